// File: rtl/rc_pulse_filter_if.sv
// rc_pulse_filter_if
//   Groups the measurement-side and output-side signals of one RC channel filter.
//   master: drives pulse_length/in_stb, observes the filtered result.
//   slave : the filter itself.
//
//   pulse_length  measured pulse length, meaningful only while in_stb=1
//   in_stb        one-cycle strobe marking a new measurement
//   value         signed offset from centre, two's complement (LEN_W+1 bits)
//   out_stb       one-cycle pulse when value/valid/lost change
//   valid         channel is tracking
//   lost          channel is in failsafe
//   sample_err    one-cycle pulse after a rejected measurement
interface rc_pulse_filter_if #(
    parameter int LEN_W = 10
);
    logic [LEN_W-1:0] pulse_length;
    logic             in_stb;
    logic [LEN_W:0]   value;
    logic             out_stb;
    logic             valid;
    logic             lost;
    logic             sample_err;

    modport master (
        output pulse_length, in_stb,
        input  value, out_stb, valid, lost, sample_err
    );

    modport slave (
        input  pulse_length, in_stb,
        output value, out_stb, valid, lost, sample_err
    );
endinterface

// File: rtl/rc_pulse_filter.sv
// rc_pulse_filter
//   Range-checks pulse-length measurements of one RC/servo channel, smooths the
//   accepted ones with a 2^AVG_LOG2 moving average, converts the result into a
//   signed offset from CENTER with a deadband, and supervises the link
//   (bad-sample run length and silence timeout) to enter a failsafe LOST state.
//
//   clk    system clock
//   reset  synchronous, active-high
//   bus    rc_pulse_filter_if.slave (pulse_length/in_stb in; value/out_stb/
//          valid/lost/sample_err out)
//
//   Latency: accepted strobe in cycle N -> buffer/sum at N+1 -> value/out_stb at N+2.
//   AVG_LOG2 must be at least 1.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ACQUIRE  | after reset, waiting for the first good sample
//   TRACK    | averaging accepted samples, value/valid live
//   LOST     | failsafe; needs GOOD_N consecutive good samples to recover
module rc_pulse_filter #(
    parameter int LEN_W       = 10,
    parameter int MIN_VALID   = 100,
    parameter int MAX_VALID   = 900,
    parameter int CENTER      = 500,
    parameter int DEADBAND    = 4,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 2000,
    parameter int BAD_LIMIT   = 3,
    parameter int GOOD_N      = 2
) (
    input logic             clk,
    input logic             reset,
    rc_pulse_filter_if.slave bus
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = LEN_W + AVG_LOG2;
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int GOOD_W = $clog2(GOOD_N + 1);

    localparam logic [LEN_W-1:0]  MIN_L     = LEN_W'(MIN_VALID);
    localparam logic [LEN_W-1:0]  MAX_L     = LEN_W'(MAX_VALID);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_N - 1);
    localparam logic signed [LEN_W:0] CENTER_S = (LEN_W+1)'(CENTER);
    localparam logic signed [LEN_W:0] DB_S     = (LEN_W+1)'(DEADBAND);

    typedef enum logic [1:0] {
        ST_ACQUIRE,
        ST_TRACK,
        ST_LOST
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]    samp_q [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q;
    logic [SUM_W-1:0]    sum_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic                upd_pend_q;

    logic [LEN_W:0]      value_q;
    logic                out_stb_q, valid_q, lost_q, sample_err_q;

    logic accept, reject, timeout_hit;
    logic do_prefill, do_update, enter_lost;

    logic [LEN_W-1:0]      avg;
    logic signed [LEN_W:0] diff, mag;
    logic                  in_db;

    assign accept = bus.in_stb && (bus.pulse_length >= MIN_L) && (bus.pulse_length <= MAX_L);
    assign reject = bus.in_stb && !accept;
    // An accepted sample in the last cycle before saturation keeps the link alive.
    assign timeout_hit = (tmo_q == TMO_LAST) && !accept;

    assign avg   = sum_q[SUM_W-1:AVG_LOG2];
    assign diff  = $signed({1'b0, avg}) - CENTER_S;
    assign mag   = diff[LEN_W] ? -diff : diff;
    assign in_db = (mag <= DB_S);

    always_comb begin
        state_d    = state_q;
        bad_d      = bad_q;
        good_d     = good_q;
        do_prefill = 1'b0;
        do_update  = 1'b0;
        enter_lost = 1'b0;
        case (state_q)
            ST_ACQUIRE: begin
                if (accept) begin
                    do_prefill = 1'b1;
                    state_d    = ST_TRACK;
                end else if (timeout_hit) begin
                    enter_lost = 1'b1;
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    do_update = 1'b1;
                    bad_d     = '0;
                end else begin
                    if (reject) begin
                        if (bad_q == BAD_LAST) enter_lost = 1'b1;
                        else                   bad_d = bad_q + 1'b1;
                    end
                    if (timeout_hit) enter_lost = 1'b1;
                end
            end
            ST_LOST: begin
                if (accept) begin
                    if (good_q == GOOD_LAST) begin
                        do_prefill = 1'b1;
                        state_d    = ST_TRACK;
                        good_d     = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end else if (reject) begin
                    good_d = '0;
                end
            end
            default: state_d = ST_ACQUIRE;
        endcase
        if (enter_lost) begin
            state_d = ST_LOST;
            bad_d   = '0;
            good_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACQUIRE;
            for (int i = 0; i < DEPTH; i++) samp_q[i] <= '0;
            ptr_q        <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            bad_q        <= '0;
            good_q       <= '0;
            upd_pend_q   <= 1'b0;
            value_q      <= '0;
            out_stb_q    <= 1'b0;
            valid_q      <= 1'b0;
            lost_q       <= 1'b0;
            sample_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bad_q        <= bad_d;
            good_q       <= good_d;
            sample_err_q <= reject;

            if (accept)                tmo_q <= '0;
            else if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;

            if (do_prefill) begin
                for (int i = 0; i < DEPTH; i++) samp_q[i] <= bus.pulse_length;
                sum_q <= {bus.pulse_length, {AVG_LOG2{1'b0}}};
                ptr_q <= '0;
            end else if (do_update) begin
                samp_q[ptr_q] <= bus.pulse_length;
                sum_q <= sum_q - SUM_W'(samp_q[ptr_q]) + SUM_W'(bus.pulse_length);
                ptr_q <= ptr_q + 1'b1;
            end

            upd_pend_q <= (do_prefill || do_update) && !enter_lost;
            out_stb_q  <= 1'b0;
            // Failsafe entry wins over an average result still in flight.
            if (enter_lost) begin
                value_q    <= '0;
                valid_q    <= 1'b0;
                lost_q     <= 1'b1;
                out_stb_q  <= 1'b1;
                upd_pend_q <= 1'b0;
            end else if (upd_pend_q) begin
                value_q   <= in_db ? '0 : diff;
                valid_q   <= 1'b1;
                lost_q    <= 1'b0;
                out_stb_q <= 1'b1;
            end
        end
    end

    assign bus.value      = value_q;
    assign bus.out_stb    = out_stb_q;
    assign bus.valid      = valid_q;
    assign bus.lost       = lost_q;
    assign bus.sample_err = sample_err_q;

endmodule

// File: tb/tb_rc_pulse_filter.sv
// tb_rc_pulse_filter
//   Scoreboard bench for rc_pulse_filter. A small reference model runs as each
//   strobe is driven and queues the expected out_stb event (cycle, value, valid,
//   lost); a monitor pops and compares whenever out_stb is seen.
module tb_rc_pulse_filter;

    localparam int LEN_W       = 10;
    localparam int TIMEOUT_CYC = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rc_pulse_filter_if #(.LEN_W(LEN_W)) bus ();

    rc_pulse_filter #(
        .LEN_W(LEN_W), .MIN_VALID(100), .MAX_VALID(900), .CENTER(500),
        .DEADBAND(4), .AVG_LOG2(2), .TIMEOUT_CYC(TIMEOUT_CYC),
        .BAD_LIMIT(3), .GOOD_N(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int value;
        int valid;
        int lost;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model: 0=ACQUIRE 1=TRACK 2=LOST
    int m_state = 0;
    int m_bad   = 0;
    int m_good  = 0;
    int m_ptr   = 0;
    int m_win[4];

    function automatic int model_value();
        int s, d;
        s = 0;
        for (int i = 0; i < 4; i++) s += m_win[i];
        d = (s / 4) - 500;
        return (d >= -4 && d <= 4) ? 0 : d;
    endfunction

    task automatic push_out(input int v, input int va, input int lo, input int c);
        exp_t e;
        e.value = v; e.valid = va; e.lost = lo; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic model_prefill(input int len);
        for (int i = 0; i < 4; i++) m_win[i] = len;
        m_ptr = 0;
    endtask

    task automatic model_lost(input int c);
        m_state = 2; m_bad = 0; m_good = 0;
        push_out(0, 0, 1, c);
    endtask

    // Drives one strobe at the current negedge; returns at the following negedge.
    task automatic send(input int len);
        int c;
        bit acc;
        c   = cyc;
        acc = (len >= 100 && len <= 900);
        bus.pulse_length = LEN_W'(len);
        bus.in_stb       = 1'b1;
        case (m_state)
            0: if (acc) begin
                model_prefill(len);
                m_state = 1;
                push_out(model_value(), 1, 0, c + 2);
            end
            1: if (acc) begin
                m_win[m_ptr] = len;
                m_ptr = (m_ptr + 1) % 4;
                m_bad = 0;
                push_out(model_value(), 1, 0, c + 2);
            end else begin
                m_bad++;
                if (m_bad == 3) model_lost(c + 1);
            end
            default: if (acc) begin
                m_good++;
                if (m_good == 2) begin
                    model_prefill(len);
                    m_state = 1;
                    m_good  = 0;
                    push_out(model_value(), 1, 0, c + 2);
                end
            end else begin
                m_good = 0;
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        bus.in_stb       = 1'b0;
        bus.pulse_length = LEN_W'($urandom_range(0, 1023));
        check_eq("sample_err", int'(bus.sample_err), int'(!acc));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_stb = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_state = 0; m_bad = 0; m_good = 0;
        check_eq("rst_value",      $signed(bus.value), 0);
        check_eq("rst_out_stb",    int'(bus.out_stb), 0);
        check_eq("rst_valid",      int'(bus.valid), 0);
        check_eq("rst_lost",       int'(bus.lost), 0);
        check_eq("rst_sample_err", int'(bus.sample_err), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check_eq("out_stb_late", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (!reset && bus.out_stb === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("out_stb_unexpected", int'(bus.out_stb), 0);
            end else begin
                e = sb.pop_front();
                check_eq("out_cyc",   cyc, e.cyc);
                check_eq("out_value", $signed(bus.value), e.value);
                check_eq("out_valid", int'(bus.valid), e.valid);
                check_eq("out_lost",  int'(bus.lost), e.lost);
            end
        end
    end

    int seq_a[12] = '{700, 700, 700, 700, 900, 100, 99, 901, 600, 99, 99, 700};
    int db_a[5]   = '{503, 495, 504, 496, 505};

    initial begin
        int t;
        bus.in_stb       = 1'b0;
        bus.pulse_length = '0;
        idle(2);

        // first sample, then averaging and accept-range boundaries
        do_reset();
        send(600);
        idle(1);
        check_eq("t1_value", $signed(bus.value), 100);
        check_eq("t1_valid", int'(bus.valid), 1);
        check_eq("t1_lost",  int'(bus.lost), 0);
        foreach (seq_a[i]) send(seq_a[i]);
        idle(3);
        check_eq("t2_valid_after_rejects", int'(bus.valid), 1);

        // deadband edges
        foreach (db_a[i]) begin
            do_reset();
            send(db_a[i]);
            idle(2);
        end

        // reject run into LOST
        do_reset();
        send(600);
        idle(2);
        send(950);
        idle(3);
        check_eq("t4_hold_value", $signed(bus.value), 100);
        send(50);
        send(50);
        check_eq("t4_lost",  int'(bus.lost), 1);
        check_eq("t4_valid", int'(bus.valid), 0);
        check_eq("t4_value", $signed(bus.value), 0);
        idle(2);

        // silence timeout
        do_reset();
        t = cyc;
        send(600);
        push_out(0, 0, 1, t + TIMEOUT_CYC + 1);
        m_state = 2; m_bad = 0; m_good = 0;
        wait_until(t + TIMEOUT_CYC);
        check_eq("t5_lost_early", int'(bus.lost), 0);
        @(negedge clk);
        check_eq("t5_lost", int'(bus.lost), 1);
        idle(2);

        // recovery from LOST
        send(600);
        send(950);
        send(600);
        check_eq("t6_still_lost", int'(bus.lost), 1);
        send(600);
        idle(2);
        check_eq("t6_lost",  int'(bus.lost), 0);
        check_eq("t6_valid", int'(bus.valid), 1);
        check_eq("t6_value", $signed(bus.value), 100);

        // accept on the saturating cycle keeps the link
        do_reset();
        t = cyc;
        send(600);
        wait_until(t + TIMEOUT_CYC);
        send(700);
        idle(4);
        check_eq("t5b_lost",  int'(bus.lost), 0);
        check_eq("t5b_value", $signed(bus.value), 125);

        // reset while a recovery result is in flight
        send(950);
        send(950);
        send(950);
        send(600);
        send(600);
        do_reset();
        idle(3);
        check_eq("t6r_out_stb", int'(bus.out_stb), 0);
        check_eq("t6r_lost",    int'(bus.lost), 0);
        send(495);
        idle(3);
        check_eq("t6r_value", $signed(bus.value), -5);

        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
